chunked_adder_unit: RTL

Parametrised, multi-cycle add/subtract/accumulate unit that succeeds the team's single-cycle bitwise half adder. Operands are accepted over a valid/ready handshake and summed CHUNK bits per cycle with full carry propagation. Results carry a registered carry-out, a signed-overflow flag and an internal accumulator. The unit sits between the tile's input-capture logic and its output mux.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/adder_chunk.sv | 22 ++
 rtl/chunked_adder_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked add/subtract/accumulate unit.
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Counter/offset widths never collapse to zero bits, even for a single chunk.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit slice adder; cmsb is the carry into the slice MSB, used for
// signed-overflow detection when this slice is the top one.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s    = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // Sum bit = a ^ b ^ carry_in, so the MSB carry-in falls out of the result bit.
  assign cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_adder_unit.sv
// Multi-cycle add/sub/accumulate unit summing CHUNK bits per enabled cycle.
// Define ADDER_SAT_EN to clamp overflowing results to the signed limits.
module chunked_adder_unit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IW     = ptr_width(NCHUNK);
  localparam int unsigned OW     = ptr_width(WIDTH);
  localparam logic [IW-1:0] LastIdx = IW'(NCHUNK - 1);

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] acc_q;
  logic [IW-1:0]    idx_q;
  logic             cy_q;

  logic [OW-1:0]    off;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] res_final;
  logic             ovf_raw;
  op_t              op_in;

  assign in_ready = (state_q == IDLE) && ena;
  assign op_in    = op_t'(op);

  assign off     = OW'(idx_q * CHUNK);
  assign slice_a = opa_q[off +: CHUNK];
  assign slice_b = opb_q[off +: CHUNK];

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (cy_q),
    .s    (slice_s),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  always_comb begin
    part_next = part_q;
    part_next[off +: CHUNK] = slice_s;
  end

  // Only meaningful on the last chunk, where the slice MSB is the word MSB.
  assign ovf_raw = slice_cmsb ^ slice_cout;

`ifdef ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

  // A wrapped result with MSB set means two positives overflowed, and vice versa.
  always_comb begin
    res_final = part_next;
    if (ovf_raw) begin
      res_final = part_next[WIDTH-1] ? SatMax : SatMin;
    end
  end
`else
  assign res_final = part_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      opa_q     <= '0;
      opb_q     <= '0;
      part_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      cy_q      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op_in;
            opa_q  <= a;
            idx_q  <= '0;
            part_q <= '0;
            cy_q   <= (op_in == OP_SUB);
            case (op_in)
              OP_SUB:  opb_q <= ~b;
              OP_ACC:  opb_q <= acc_q;
              default: opb_q <= b;
            endcase
            if (op_in == OP_CLR) begin
              state_q   <= DONE;
              acc_q     <= '0;
              sum       <= '0;
              carry     <= 1'b0;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end

        CALC: begin
          part_q <= part_next;
          cy_q   <= slice_cout;
          if (idx_q == LastIdx) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
            sum       <= res_final;
            carry     <= slice_cout;
            ovf       <= ovf_raw;
            if (op_q == OP_ACC) begin
              acc_q <= res_final;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
